// File: rtl/lcd_ctrl_param_if.sv
// ---------------------------------------------------------------------------
// lcd_ctrl_param_if
// Bundles the command-host, IROM and IRAM signals of lcd_ctrl_param.
//   slave  : the controller side (drives IROM_rd/IROM_A, IRAM_*, busy, done)
//   master : the environment side (drives cmd, cmd_valid, IROM_Q)
// Handshake: a command is taken on a rising clock edge where cmd_valid=1 and
// busy=0. busy is the inverse of ready; cmd_valid raised while busy=1 is
// dropped, never queued.
// Parameters: DW pixel width, AW = log2(number of pixels).
// ---------------------------------------------------------------------------
interface lcd_ctrl_param_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] IROM_Q;
  logic          IROM_rd;
  logic [AW-1:0] IROM_A;
  logic          IRAM_valid;
  logic [DW-1:0] IRAM_D;
  logic [AW-1:0] IRAM_A;
  logic          busy;
  logic          done;

  modport slave (
    input  cmd, cmd_valid, IROM_Q,
    output IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );

  modport master (
    output cmd, cmd_valid, IROM_Q,
    input  IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );
endinterface

// File: rtl/lcd_ctrl_param.sv
// ---------------------------------------------------------------------------
// lcd_ctrl_param
// Parametrised LCD image controller. Loads a 2**XW x 2**YW image from a
// synchronous IROM into an internal buffer, runs cursor-move and 2x2 window
// commands on it one at a time, and on command 0 streams the buffer to IRAM
// and pulses done, after which it halts until reset.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   bus          lcd_ctrl_param_if.slave (cmd/cmd_valid, IROM_*, IRAM_*,
//                busy, done)
//   dbg_state_o  current FSM state encoding
// Optional feature: define LCD_CTRL_ROUND_EN to make the average command round
// half-up ((sum+2)>>2); otherwise it truncates (sum>>2).
// Handshake: a command is taken on a rising edge with cmd_valid=1 and
// busy=0; while busy=1 cmd_valid is ignored.
// ---------------------------------------------------------------------------
module lcd_ctrl_param #(
  parameter int DW = 8,
  parameter int XW = 3,
  parameter int YW = 3,
  parameter int X0 = 4,
  parameter int Y0 = 4
) (
  input  logic             clk,
  input  logic             reset,
  lcd_ctrl_param_if.slave  bus,
  output logic [2:0]       dbg_state_o
);
  localparam int AW = XW + YW;
  localparam int N  = 1 << AW;
  localparam logic [AW:0]   LOAD_END = (AW+1)'(N);
  localparam logic [AW:0]   WR_LAST  = (AW+1)'(N - 1);
  localparam logic [XW-1:0] X_MAX    = XW'((1 << XW) - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'((1 << YW) - 1);
  localparam logic [XW-1:0] X_HOME   = XW'(X0);
  localparam logic [YW-1:0] Y_HOME   = YW'(Y0);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_PROC, S_WRITE, S_DONE, S_HALT
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [DW-1:0] buf_q [N];

  assign dbg_state_o = state_q;

  // 2x2 window: p0=(x-1,y-1) p1=(x,y-1) p2=(x-1,y) p3=(x,y), address {y,x}
  logic [XW-1:0] xm1;
  logic [YW-1:0] ym1;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [DW-1:0] p0, p1, p2, p3;
  logic [DW-1:0] mx01, mx23, mx, mn01, mn23, mn, avg;
  logic [DW+1:0] sum;
  logic [DW-1:0] n0, n1, n2, n3;
  logic          win_we;

  assign xm1 = x_q - XW'(1);
  assign ym1 = y_q - YW'(1);
  assign a0  = {ym1, xm1};
  assign a1  = {ym1, x_q};
  assign a2  = {y_q, xm1};
  assign a3  = {y_q, x_q};
  assign p0  = buf_q[a0];
  assign p1  = buf_q[a1];
  assign p2  = buf_q[a2];
  assign p3  = buf_q[a3];

  assign mx01 = (p0 > p1) ? p0 : p1;
  assign mx23 = (p2 > p3) ? p2 : p3;
  assign mx   = (mx01 > mx23) ? mx01 : mx23;
  assign mn01 = (p0 < p1) ? p0 : p1;
  assign mn23 = (p2 < p3) ? p2 : p3;
  assign mn   = (mn01 < mn23) ? mn01 : mn23;
  assign sum  = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
`ifdef LCD_CTRL_ROUND_EN
  // sum+2 still fits DW+2 bits, so the quotient always fits DW bits
  assign avg  = DW'((sum + (DW+2)'(2)) >> 2);
`else
  assign avg  = DW'(sum >> 2);
`endif

  always_comb begin : window_ops
    win_we = 1'b0;
    n0 = p0;
    n1 = p1;
    n2 = p2;
    n3 = p3;
    case (op_q)
      4'd5:  begin win_we = 1'b1; n0 = mx;  n1 = mx;  n2 = mx;  n3 = mx;  end
      4'd6:  begin win_we = 1'b1; n0 = mn;  n1 = mn;  n2 = mn;  n3 = mn;  end
      4'd7:  begin win_we = 1'b1; n0 = avg; n1 = avg; n2 = avg; n3 = avg; end
      4'd8:  begin win_we = 1'b1; n0 = p1;  n1 = p3;  n2 = p0;  n3 = p2;  end
      4'd9:  begin win_we = 1'b1; n0 = p2;  n1 = p0;  n2 = p3;  n3 = p1;  end
      4'd10: begin win_we = 1'b1; n0 = p2;  n1 = p3;  n2 = p0;  n3 = p1;  end
      4'd11: begin win_we = 1'b1; n0 = p1;  n1 = p0;  n2 = p3;  n3 = p2;  end
      default: ;
    endcase
  end

  always_comb begin : fsm_next
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    x_d            = x_q;
    y_d            = y_q;
    bus.busy       = 1'b1;
    bus.done       = 1'b0;
    bus.IROM_rd    = 1'b0;
    bus.IROM_A     = '0;
    bus.IRAM_valid = 1'b0;
    bus.IRAM_A     = '0;
    bus.IRAM_D     = '0;
    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        state_d = S_LOAD;
      end
      // cnt 0..N-1 issue reads; cnt N is the drain cycle for the last capture
      S_LOAD: begin
        if (cnt_q != LOAD_END) begin
          bus.IROM_rd = 1'b1;
          bus.IROM_A  = cnt_q[AW-1:0];
          cnt_d       = cnt_q + 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        bus.busy = 1'b0;
        if (bus.cmd_valid) begin
          if (bus.cmd == 4'd0) begin
            cnt_d   = '0;
            state_d = S_WRITE;
          end else begin
            op_d    = bus.cmd;
            state_d = S_PROC;
          end
        end
      end
      S_PROC: begin
        case (op_q)
          4'd1:  if (y_q != YW'(1)) y_d = y_q - YW'(1);
          4'd2:  if (y_q != Y_MAX)  y_d = y_q + YW'(1);
          4'd3:  if (x_q != XW'(1)) x_d = x_q - XW'(1);
          4'd4:  if (x_q != X_MAX)  x_d = x_q + XW'(1);
          4'd12: begin x_d = X_HOME; y_d = Y_HOME; end
          default: ;
        endcase
        state_d = S_WAIT;
      end
      S_WRITE: begin
        bus.IRAM_valid = 1'b1;
        bus.IRAM_A     = cnt_q[AW-1:0];
        bus.IRAM_D     = buf_q[cnt_q[AW-1:0]];
        if (cnt_q == WR_LAST) state_d = S_DONE;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_HALT;
      end
      default: ;  // S_HALT: wait for reset
    endcase
  end

  always_ff @(posedge clk) begin : fsm_regs
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      x_q     <= X_HOME;
      y_q     <= Y_HOME;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // IROM_Q lags the address by one cycle, so capture into cnt-1
  logic [AW-1:0] cap_addr;
  assign cap_addr = AW'(cnt_q - 1'b1);

  always_ff @(posedge clk) begin : pixel_buffer
    if (!reset) begin
      if (state_q == S_LOAD && cnt_q != '0) begin
        buf_q[cap_addr] <= bus.IROM_Q;
      end else if (state_q == S_PROC && win_we) begin
        buf_q[a0] <= n0;
        buf_q[a1] <= n1;
        buf_q[a2] <= n2;
        buf_q[a3] <= n3;
      end
    end
  end
endmodule
